// File: rtl/ps2_scan_rx_pkg.sv
// ps2_pkg: shared types and constants for the PS/2 scan-code receiver.
//   ps2_state_t     - frame deserialiser states
//   PS2_PREFIX_EXT  - extended-key prefix byte
//   PS2_PREFIX_BRK  - break (release) prefix byte
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_t;

  localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

endpackage

// File: rtl/ps2_scan_rx_if.sv
// ps2_scan_rx_if: key-event bundle from the PS/2 receiver to its consumer.
//   scan_code  - last decoded scan code (prefix bytes excluded)
//   key_action - 1 = make, 0 = break
//   extended   - scan code was preceded by 0xE0
//   code_valid - one-cycle strobe, the three fields above are new
//   frame_err  - one-cycle strobe, a frame was discarded
// modport master drives the bundle, slave observes it.
interface ps2_scan_rx_if;
  logic [7:0] scan_code;
  logic       key_action;
  logic       extended;
  logic       code_valid;
  logic       frame_err;

  modport master (output scan_code, key_action, extended, code_valid, frame_err);
  modport slave  (input  scan_code, key_action, extended, code_valid, frame_err);
endinterface

// File: rtl/ps2_sync_edge.sv
// ps2_sync_edge: 2-FF synchronisers on both PS/2 pins plus a falling-edge
// detector on the synchronised clock.
//   clk, rst         - system clock, async active-high reset
//   ps2_clk, ps2_dat - raw pins, asynchronous to clk
//   dat_s            - synchronised data pin
//   fe               - one-cycle strobe on a falling edge of ps2_clk
module ps2_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic ps2_clk,
  input  logic ps2_dat,
  output logic dat_s,
  output logic fe
);
  logic [1:0] clk_sync;
  logic [1:0] dat_sync;
  logic       clk_q;

  // Reset to the idle-high pin level so leaving reset never fakes an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
      clk_q    <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_dat};
      clk_q    <= clk_sync[1];
    end
  end

  assign fe    = clk_q & ~clk_sync[1];
  assign dat_s = dat_sync[1];
endmodule

// File: rtl/ps2_scan_rx.sv
// ps2_scan_rx: PS/2 device-to-host frame receiver with E0/F0 prefix decode.
//   CLOCK_50         - system clock
//   reset            - async active-high reset
//   ps2_clk, ps2_dat - raw PS/2 pins
//   evt              - key-event bundle (scan_code, key_action, extended,
//                      code_valid, frame_err)
// Build option: define PS2_PARITY_CHECK_EN to reject frames whose parity
// is not odd over data+parity; otherwise only the stop bit is judged.
module ps2_scan_rx
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic          CLOCK_50,
  input  logic          reset,
  input  logic          ps2_clk,
  input  logic          ps2_dat,
  ps2_scan_rx_if.master evt
);
  localparam int WD_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic dat_s, fe;

  ps2_sync_edge u_sync (
    .clk     (CLOCK_50),
    .rst     (reset),
    .ps2_clk (ps2_clk),
    .ps2_dat (ps2_dat),
    .dat_s   (dat_s),
    .fe      (fe)
  );

  ps2_state_t      state, state_n;
  logic [2:0]      bit_cnt, bit_cnt_n;
  logic [7:0]      sh, sh_n;
  logic            par, par_n;
  logic            ext_pend, ext_pend_n, brk_pend, brk_pend_n;
  logic [WD_W-1:0] wd, wd_n;
  logic [7:0]      code_q, code_n;
  logic            act_q, act_n, ext_q, ext_n, cv_q, cv_n, err_q, err_n;
  logic            timeout, good;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      sh       <= '0;
      par      <= 1'b0;
      ext_pend <= 1'b0;
      brk_pend <= 1'b0;
      wd       <= '0;
      code_q   <= '0;
      act_q    <= 1'b0;
      ext_q    <= 1'b0;
      cv_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state    <= state_n;
      bit_cnt  <= bit_cnt_n;
      sh       <= sh_n;
      par      <= par_n;
      ext_pend <= ext_pend_n;
      brk_pend <= brk_pend_n;
      wd       <= wd_n;
      code_q   <= code_n;
      act_q    <= act_n;
      ext_q    <= ext_n;
      cv_q     <= cv_n;
      err_q    <= err_n;
    end
  end

  always_comb begin
    state_n    = state;
    bit_cnt_n  = bit_cnt;
    sh_n       = sh;
    par_n      = par;
    ext_pend_n = ext_pend;
    brk_pend_n = brk_pend;
    code_n     = code_q;
    act_n      = act_q;
    ext_n      = ext_q;
    cv_n       = 1'b0;
    err_n      = 1'b0;
    good       = 1'b0;
    wd_n       = (state == IDLE || fe) ? '0 : wd + 1'b1;
    timeout    = (state != IDLE) && (wd == WD_W'(TIMEOUT_CYC - 1));

    // Timeout takes priority over a coincident edge.
    if (timeout) begin
      state_n    = IDLE;
      wd_n       = '0;
      err_n      = 1'b1;
      ext_pend_n = 1'b0;
      brk_pend_n = 1'b0;
    end else if (fe) begin
      unique case (state)
        IDLE: if (!dat_s) begin
          state_n   = DATA;
          bit_cnt_n = '0;
        end
        DATA: begin
          sh_n      = {dat_s, sh[7:1]};
          bit_cnt_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_n = PARITY;
        end
        PARITY: begin
          par_n   = dat_s;
          state_n = STOP;
        end
        STOP: begin
          state_n = IDLE;
`ifdef PS2_PARITY_CHECK_EN
          good = dat_s && (^{sh, par});
`else
          good = dat_s;
`endif
          if (!good) begin
            err_n      = 1'b1;
            ext_pend_n = 1'b0;
            brk_pend_n = 1'b0;
          end else if (sh == PS2_PREFIX_EXT) begin
            ext_pend_n = 1'b1;
          end else if (sh == PS2_PREFIX_BRK) begin
            brk_pend_n = 1'b1;
          end else begin
            code_n     = sh;
            act_n      = !brk_pend;
            ext_n      = ext_pend;
            cv_n       = 1'b1;
            ext_pend_n = 1'b0;
            brk_pend_n = 1'b0;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign evt.scan_code  = code_q;
  assign evt.key_action = act_q;
  assign evt.extended   = ext_q;
  assign evt.code_valid = cv_q;
  assign evt.frame_err  = err_q;
endmodule

// File: tb/tb_ps2_scan_rx.sv
module tb_ps2_scan_rx;
  localparam int TO   = 200;
  localparam int HALF = 20;

  logic clk = 1'b0, rst = 1'b1, ps2_clk = 1'b1, ps2_dat = 1'b1;
  ps2_scan_rx_if evt();

  ps2_scan_rx #(.TIMEOUT_CYC(TO)) dut (
    .CLOCK_50 (clk),
    .reset    (rst),
    .ps2_clk  (ps2_clk),
    .ps2_dat  (ps2_dat),
    .evt      (evt)
  );

  always #5 clk = ~clk;

  typedef struct { bit err; logic [7:0] code; bit act; bit ext; } ev_t;
  ev_t exp_q[$];

  int total = 0, bad = 0;
  bit m_ext = 0, m_brk = 0;
  logic [7:0] h_code = 0;
  logic h_act = 0, h_ext = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, expv, $time);
    end
  endfunction

  // Model: a frame is a byte plus its parity/stop bits; decide the event.
  function automatic void model_frame(logic [7:0] d, logic p, logic stop);
    bit ok;
    ev_t e;
    ok = stop;
`ifdef PS2_PARITY_CHECK_EN
    ok = ok && ((^d ^ p) == 1'b1);
`endif
    if (!ok) begin
      e = '{1'b1, 8'h00, 1'b0, 1'b0}; exp_q.push_back(e);
      m_ext = 0; m_brk = 0;
    end else if (d == 8'hE0) m_ext = 1;
    else if (d == 8'hF0) m_brk = 1;
    else begin
      e = '{1'b0, d, !m_brk, m_ext}; exp_q.push_back(e);
      m_ext = 0; m_brk = 0;
    end
  endfunction

  task automatic send_bits(logic [10:0] bits, int n);
    for (int i = 0; i < n; i++) begin
      ps2_dat = bits[i];
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b1;
    end
    ps2_dat = 1'b1;
  endtask

  task automatic frame(logic [7:0] d, bit par_ok, logic stop);
    logic p;
    p = par_ok ? ~^d : ^d;
    model_frame(d, p, stop);
    send_bits({stop, p, d, 1'b0}, 11);
    repeat (30) @(negedge clk);
  endtask

  // Per-cycle compare against the model's event queue and held values.
  always @(negedge clk) begin
    ev_t e;
    if (!rst) begin
      chk("excl", {31'd0, evt.code_valid & evt.frame_err}, 0);
      if (evt.code_valid || evt.frame_err) begin
        if (exp_q.size() == 0) chk("unexpected_evt", {evt.code_valid, evt.frame_err}, 0);
        else begin
          e = exp_q.pop_front();
          chk("evt_kind", {30'd0, evt.code_valid, evt.frame_err}, {30'd0, !e.err, e.err});
          if (!e.err) begin h_code = e.code; h_act = e.act; h_ext = e.ext; end
        end
      end
      chk("scan_code", evt.scan_code, h_code);
      chk("key_action", evt.key_action, h_act);
      chk("extended", evt.extended, h_ext);
    end
  end

  task automatic drained(string nm);
    chk(nm, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_code", evt.scan_code, 0);
    chk("rst_act", evt.key_action, 0);
    chk("rst_ext", evt.extended, 0);
    chk("rst_cv", evt.code_valid, 0);
    chk("rst_err", evt.frame_err, 0);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // plain make
    frame(8'h1C, 1, 1);
    drained("drain_1c");
    chk("lit_1c_code", evt.scan_code, 8'h1C);
    chk("lit_1c_act", evt.key_action, 1);
    chk("lit_1c_ext", evt.extended, 0);

    // stray edge with data high is ignored
    send_bits(11'h001, 1);
    repeat (30) @(negedge clk);
    drained("drain_stray");

    // break
    frame(8'hF0, 1, 1);
    drained("drain_f0");
    frame(8'h1C, 1, 1);
    drained("drain_brk");
    chk("lit_brk_act", evt.key_action, 0);

    // extended break, then plain make
    frame(8'hE0, 1, 1);
    frame(8'hF0, 1, 1);
    frame(8'h75, 1, 1);
    drained("drain_e0f075");
    chk("lit_75_code", evt.scan_code, 8'h75);
    chk("lit_75_act", evt.key_action, 0);
    chk("lit_75_ext", evt.extended, 1);
    frame(8'h29, 1, 1);
    drained("drain_29");
    chk("lit_29_ext", evt.extended, 0);
    chk("lit_29_act", evt.key_action, 1);

    // bad parity (build dependent), bad stop bit, prefix cleared by error
    frame(8'h1C, 0, 1);
    drained("drain_par");
    frame(8'hF0, 1, 1);
    frame(8'h1C, 1, 0);
    drained("drain_stop");
    frame(8'h2A, 1, 1);
    drained("drain_after_err");
    chk("lit_2a_act", evt.key_action, 1);

    // watchdog: start + 4 data bits then silence
    begin
      ev_t e;
      frame(8'hE0, 1, 1);
      e = '{1'b1, 8'h00, 1'b0, 1'b0};
      exp_q.push_back(e);
      m_ext = 0; m_brk = 0;
      send_bits(11'b0_1010_0, 5);
      repeat (TO + 30) @(negedge clk);
      drained("drain_timeout");
    end
    frame(8'h29, 1, 1);
    drained("drain_after_to");
    chk("lit_to_ext", evt.extended, 0);

    // reset mid-frame drops the pending break
    frame(8'hF0, 1, 1);
    send_bits(11'b0_0110, 4);
    rst = 1'b1;
    exp_q.delete();
    m_ext = 0; m_brk = 0; h_code = 0; h_act = 0; h_ext = 0;
    repeat (3) @(negedge clk);
    chk("mid_rst_code", evt.scan_code, 0);
    chk("mid_rst_act", evt.key_action, 0);
    chk("mid_rst_cv", evt.code_valid, 0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    frame(8'h1C, 1, 1);
    drained("drain_post_rst");
    chk("lit_post_rst_act", evt.key_action, 1);
    chk("lit_post_rst_code", evt.scan_code, 8'h1C);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
